pc_unit: RTL
============

// Module: pc_unit
// PURPOSE
//  Registered program-counter unit for the MIPS fetch stage: holds PC, computes next PC
//  (sequential, branch, jump, jump-register, exception entry, ERET) and owns the EPC register.
//  Buffers redirects that arrive while fetch is stalled and applies them on release.
//  Sits between decode/control (npc_op, immediates, rs) and instruction memory (pc).
// PARAMETERS
//  AW         32            PC/address width; must be >= 28
//  RESET_VEC  32'h0000_3000 PC value after reset
//  EXC_VEC    32'h0000_4180 exception entry address
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   synchronous reset, active-high
//  stall       in   1   1 = hold PC this cycle (imem/pipeline not ready)
//  npc_op      in   3   next-PC select (encodings in package)
//  d_ins26     in   26  jump index field
//  d_ext32     in   32  sign-extended branch offset (words)
//  d_rs        in   AW  jump-register target
//  exc_req     in   1   exception request (pulse)
//  eret        in   1   return from exception (pulse)
//  pc          out  AW  current PC (fetch address)
//  pc_plus4    out  AW  pc + 4, combinational
//  epc         out  AW  saved exception PC
//  pend_valid  out  1   a redirect is buffered
//  addr_err    out  1   1-cycle pulse: misaligned jr target detected
// BEHAVIOUR
//  - Reset (clk edge with rst=1): pc=RESET_VEC, epc=0, pend_valid=0, addr_err=0; rst beats all.
//  - Targets (all mod 2^AW): SEQ 000 -> pc+4; BR 001 -> pc+4+{d_ext32[AW-3:0],2'b00};
//    J 010 -> {pc[AW-1:28],d_ins26,2'b00}; JR 011 -> d_rs; 100-111 reserved -> treated as SEQ.
//  - JR with d_rs[1:0]!=0: target becomes EXC_VEC, epc<=pc, addr_err pulses next cycle.
//  - Request priority in a cycle: exc_req > eret > misaligned JR > npc_op.
//  - exc_req: target=EXC_VEC, epc<=pc (PC of the excepting fetch) at that edge.
//  - eret: target=epc value before the edge; epc unchanged.
//  - Any non-SEQ request (incl. exc/eret) is a "redirect"; SEQ is not.
//  - stall=0, no pending: pc<=target on the edge (1-cycle latency, no bubble).
//  - stall=1: pc holds. A redirect this cycle is written to pend_tgt, pend_valid<=1.
//    Later redirect while stalled overwrites pend_tgt, except a buffered exception target
//    is only overwritten by another exc_req. SEQ during stall changes nothing.
//  - stall 1->0 with pend_valid: if a redirect is presented that same cycle it wins (newest);
//    otherwise pc<=pend_tgt. pend_valid<=0 either way. epc updates at capture time, not release.
//  - stall=0 and pend_valid cannot coexist across two edges (pend cleared on first free edge).
//  - pc[1:0] always 2'b00 given aligned vectors; addr_err is the only alignment report.
// STRUCTURE
//  - Package pc_unit_pkg: npc_op localparams (OP_SEQ, OP_BR, OP_J, OP_JR), op width constant,
//    default vector constants.
//  - Sub-module npc_target_calc: combinational target/priority mux + misalignment detect;
//    pc_unit keeps pc, epc, pend_tgt, pend_valid, pend_is_exc, addr_err registers.
// TESTING
//  - Reset: rst=1 one cycle -> pc=0x3000, epc=0, pend_valid=0; 3x SEQ -> 0x3004,0x3008,0x300C.
//  - Branch: pc=0x3010, BR, d_ext32=0xFFFF_FFFE -> pc=0x300C; d_ext32=3 -> 0x3020.
//  - Jump/JR: pc=0x3000, J, d_ins26=0x0000C10 -> 0x3040; JR d_rs=0x0000_5002 -> pc=0x4180,
//    epc=0x3040-path PC, addr_err=1 for exactly one cycle.
//  - Exception/ERET: pc=0x3008, exc_req with BR same cycle -> pc=0x4180, epc=0x3008;
//    then eret -> pc=0x3008.
//  - Stall buffering: stall=1, J to 0x3400 then SEQ x2 -> pc frozen, pend_valid=1;
//    stall=0 -> pc=0x3400, pend_valid=0; repeat with exc_req then J during stall -> pc=0x4180.
//  - Release race + reset mid-stall: pending J 0x3400, release cycle presents JR 0x3800 ->
//    pc=0x3800; pending redirect then rst=1 -> pc=0x3000, pend_valid=0.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared constants for the fetch-stage program-counter unit.
// Next-PC select encodings and default vector addresses.
package pc_unit_pkg;

    localparam int unsigned NPC_OP_W = 3;

    localparam logic [NPC_OP_W-1:0] OP_SEQ = 3'b000;
    localparam logic [NPC_OP_W-1:0] OP_BR  = 3'b001;
    localparam logic [NPC_OP_W-1:0] OP_J   = 3'b010;
    localparam logic [NPC_OP_W-1:0] OP_JR  = 3'b011;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;

endpackage

// File: rtl/pc_unit_npc_target_calc.sv
// Combinational next-PC target selection with request priority
// and misaligned jump-register detection.
module npc_target_calc
    import pc_unit_pkg::*;
#(
    parameter int unsigned    AW      = 32,
    parameter logic [AW-1:0]  EXC_VEC = AW'(DEF_EXC_VEC)
) (
    input  logic [AW-1:0]       pc,
    input  logic [AW-1:0]       epc,
    input  logic [NPC_OP_W-1:0] npc_op,
    input  logic [25:0]         d_ins26,
    input  logic [31:0]         d_ext32,
    input  logic [AW-1:0]       d_rs,
    input  logic                exc_req,
    input  logic                eret,
    output logic [AW-1:0]       target,
    output logic                redirect,
    output logic                exc_entry,
    output logic                misalign
);

    logic [AW-1:0] seq_tgt;
    logic [AW-1:0] br_off;
    logic [AW-1:0] br_tgt;
    logic [AW-1:0] j_tgt;
    logic          jr_bad;

    assign seq_tgt = pc + AW'(4);
    // Low AW bits of the word offset scaled to bytes, sign-extended if AW > 34
    assign br_off  = AW'($signed({d_ext32, 2'b00}));
    assign br_tgt  = seq_tgt + br_off;
    assign jr_bad  = (npc_op == OP_JR) && (d_rs[1:0] != 2'b00);

    always_comb begin
        j_tgt       = pc;
        j_tgt[27:0] = {d_ins26, 2'b00};
    end

    always_comb begin
        target    = seq_tgt;
        redirect  = 1'b0;
        exc_entry = 1'b0;
        misalign  = 1'b0;
        if (exc_req) begin
            target    = EXC_VEC;
            redirect  = 1'b1;
            exc_entry = 1'b1;
        end else if (eret) begin
            target   = epc;
            redirect = 1'b1;
        end else if (jr_bad) begin
            target    = EXC_VEC;
            redirect  = 1'b1;
            exc_entry = 1'b1;
            misalign  = 1'b1;
        end else begin
            case (npc_op)
                OP_BR: begin
                    target   = br_tgt;
                    redirect = 1'b1;
                end
                OP_J: begin
                    target   = j_tgt;
                    redirect = 1'b1;
                end
                OP_JR: begin
                    target   = d_rs;
                    redirect = 1'b1;
                end
                default: target = seq_tgt;
            endcase
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Registered program counter and EPC for the fetch stage; buffers
// redirects that arrive while fetch is stalled and applies them on release.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned    AW        = 32,
    parameter logic [AW-1:0]  RESET_VEC = AW'(DEF_RESET_VEC),
    parameter logic [AW-1:0]  EXC_VEC   = AW'(DEF_EXC_VEC)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic [NPC_OP_W-1:0] npc_op,
    input  logic [25:0]         d_ins26,
    input  logic [31:0]         d_ext32,
    input  logic [AW-1:0]       d_rs,
    input  logic                exc_req,
    input  logic                eret,
    output logic [AW-1:0]       pc,
    output logic [AW-1:0]       pc_plus4,
    output logic [AW-1:0]       epc,
    output logic                pend_valid,
    output logic                addr_err
);

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] epc_q, epc_d;
    logic [AW-1:0] pend_tgt_q, pend_tgt_d;
    logic          pend_valid_q, pend_valid_d;
    logic          pend_is_exc_q, pend_is_exc_d;
    logic          addr_err_q, addr_err_d;

    logic [AW-1:0] target;
    logic          redirect;
    logic          exc_entry;
    logic          misalign;
    logic          accept;

    npc_target_calc #(
        .AW      (AW),
        .EXC_VEC (EXC_VEC)
    ) u_calc (
        .pc        (pc_q),
        .epc       (epc_q),
        .npc_op    (npc_op),
        .d_ins26   (d_ins26),
        .d_ext32   (d_ext32),
        .d_rs      (d_rs),
        .exc_req   (exc_req),
        .eret      (eret),
        .target    (target),
        .redirect  (redirect),
        .exc_entry (exc_entry),
        .misalign  (misalign)
    );

    // A buffered exception entry may only be displaced by a newer exc_req
    assign accept = redirect &&
                    (!stall || !pend_valid_q || !pend_is_exc_q || exc_req);

    always_comb begin
        pc_d          = pc_q;
        epc_d         = epc_q;
        pend_tgt_d    = pend_tgt_q;
        pend_valid_d  = pend_valid_q;
        pend_is_exc_d = pend_is_exc_q;
        addr_err_d    = 1'b0;
        if (stall) begin
            if (accept) begin
                pend_tgt_d    = target;
                pend_valid_d  = 1'b1;
                pend_is_exc_d = exc_entry;
            end
        end else begin
            pend_valid_d  = 1'b0;
            pend_is_exc_d = 1'b0;
            if (!redirect && pend_valid_q) begin
                pc_d = pend_tgt_q;
            end else begin
                pc_d = target;
            end
        end
        if (accept && exc_entry) begin
            epc_d = pc_q;
        end
        if (accept && misalign) begin
            addr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_VEC;
            epc_q         <= '0;
            pend_tgt_q    <= RESET_VEC;
            pend_valid_q  <= 1'b0;
            pend_is_exc_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            pend_tgt_q    <= pend_tgt_d;
            pend_valid_q  <= pend_valid_d;
            pend_is_exc_q <= pend_is_exc_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign pc         = pc_q;
    assign pc_plus4   = pc_q + AW'(4);
    assign epc        = epc_q;
    assign pend_valid = pend_valid_q;
    assign addr_err   = addr_err_q;

endmodule
